// File: rtl/jpeg_mcu_sched_if.sv
// Handshake and status bundle between the coefficient path / front end and the MCU block sequencer.
interface jpeg_mcu_sched_if #(
    parameter int unsigned MCU_W = 16
);
    logic             img_start_i;
    logic [1:0]       cfg_mode_i;
    logic [MCU_W-1:0] cfg_mcu_total_i;
    logic [MCU_W-1:0] cfg_restart_i;
    logic             blk_done_i;
    logic             restart_ack_i;
    logic             active_o;
    logic [1:0]       comp_id_o;
    logic [2:0]       blk_idx_o;
    logic             dc_reset_o;
    logic             restart_req_o;
    logic             img_end_o;
    logic             err_o;

    modport master (
        output img_start_i, cfg_mode_i, cfg_mcu_total_i, cfg_restart_i, blk_done_i, restart_ack_i,
        input  active_o, comp_id_o, blk_idx_o, dc_reset_o, restart_req_o, img_end_o, err_o
    );

    modport slave (
        input  img_start_i, cfg_mode_i, cfg_mcu_total_i, cfg_restart_i, blk_done_i, restart_ack_i,
        output active_o, comp_id_o, blk_idx_o, dc_reset_o, restart_req_o, img_end_o, err_o
    );
endinterface

// File: rtl/jpeg_mcu_sched.sv
// MCU block sequencer: tracks component/block position per accepted end-of-block,
// counts MCUs, pauses for restart markers and flags end of image.
module jpeg_mcu_sched #(
    parameter int unsigned MCU_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    jpeg_mcu_sched_if.slave         bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACTIVE  = 2'd1;
    localparam logic [1:0] S_RESTART = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [MCU_W-1:0] total_q, total_d;
    logic [MCU_W-1:0] rst_int_q, rst_int_d;
    logic [MCU_W-1:0] mcu_cnt_q, mcu_cnt_d;
    logic [MCU_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [2:0]       blk_idx_q, blk_idx_d;
    logic [1:0]       comp_id_q, comp_id_d;
    logic             active_q, active_d;
    logic             req_q, req_d;
    logic             dc_reset_q, dc_reset_d;
    logic             img_end_q, img_end_d;
    logic             err_q, err_d;

    logic [MCU_W-1:0] mcu_inc;
    logic [MCU_W-1:0] rst_inc;
    logic [2:0]       last_idx;

    assign mcu_inc = mcu_cnt_q + MCU_W'(1);
    assign rst_inc = rst_cnt_q + MCU_W'(1);

    // Index of the final block in an MCU (blocks per MCU minus one).
    always_comb begin
        case (mode_q)
            2'd0:    last_idx = 3'd0;
            2'd1:    last_idx = 3'd2;
            2'd2:    last_idx = 3'd5;
            default: last_idx = 3'd3;
        endcase
    end

    function automatic logic [1:0] comp_of(input logic [1:0] mode, input logic [2:0] idx);
        logic [1:0] c;
        c = 2'd0;
        case (mode)
            2'd1:    c = idx[1:0];
            2'd2:    c = (idx == 3'd4) ? 2'd1 : ((idx == 3'd5) ? 2'd2 : 2'd0);
            2'd3:    c = (idx == 3'd2) ? 2'd1 : ((idx == 3'd3) ? 2'd2 : 2'd0);
            default: c = 2'd0;
        endcase
        return c;
    endfunction

    // Next-state and next-output logic; img_start_i overrides everything.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        total_d    = total_q;
        rst_int_d  = rst_int_q;
        mcu_cnt_d  = mcu_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        blk_idx_d  = blk_idx_q;
        dc_reset_d = 1'b0;
        img_end_d  = 1'b0;
        err_d      = err_q;

        if (bus.img_start_i) begin
            state_d    = S_ACTIVE;
            mode_d     = bus.cfg_mode_i;
            total_d    = bus.cfg_mcu_total_i;
            rst_int_d  = bus.cfg_restart_i;
            mcu_cnt_d  = '0;
            rst_cnt_d  = '0;
            blk_idx_d  = 3'd0;
            dc_reset_d = 1'b1;
            err_d      = 1'b0;
        end else begin
            // Blocks are only legal while actively sequencing a non-empty image.
            if (bus.blk_done_i && ((state_q != S_ACTIVE) || (total_q == '0)))
                err_d = 1'b1;
            case (state_q)
                S_ACTIVE: begin
                    if (total_q == '0) begin
                        state_d   = S_DONE;
                        img_end_d = 1'b1;
                        blk_idx_d = 3'd0;
                    end else if (bus.blk_done_i) begin
                        if (blk_idx_q != last_idx) begin
                            blk_idx_d = blk_idx_q + 3'd1;
                        end else begin
                            blk_idx_d = 3'd0;
                            mcu_cnt_d = mcu_inc;
                            rst_cnt_d = rst_inc;
                            if (mcu_inc == total_q) begin
                                state_d   = S_DONE;
                                img_end_d = 1'b1;
                            end else if ((rst_int_q != '0) && (rst_inc == rst_int_q)) begin
                                state_d   = S_RESTART;
                                rst_cnt_d = '0;
                            end
                        end
                    end
                end
                S_RESTART: begin
                    if (bus.restart_ack_i) begin
                        state_d    = S_ACTIVE;
                        dc_reset_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        comp_id_d = comp_of(mode_d, blk_idx_d);
        active_d  = (state_d == S_ACTIVE);
        req_d     = (state_d == S_RESTART);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'd0;
            total_q    <= '0;
            rst_int_q  <= '0;
            mcu_cnt_q  <= '0;
            rst_cnt_q  <= '0;
            blk_idx_q  <= 3'd0;
            comp_id_q  <= 2'd0;
            active_q   <= 1'b0;
            req_q      <= 1'b0;
            dc_reset_q <= 1'b0;
            img_end_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            total_q    <= total_d;
            rst_int_q  <= rst_int_d;
            mcu_cnt_q  <= mcu_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            blk_idx_q  <= blk_idx_d;
            comp_id_q  <= comp_id_d;
            active_q   <= active_d;
            req_q      <= req_d;
            dc_reset_q <= dc_reset_d;
            img_end_q  <= img_end_d;
            err_q      <= err_d;
        end
    end

    assign bus.active_o      = active_q;
    assign bus.comp_id_o     = comp_id_q;
    assign bus.blk_idx_o     = blk_idx_q;
    assign bus.dc_reset_o    = dc_reset_q;
    assign bus.restart_req_o = req_q;
    assign bus.img_end_o     = img_end_q;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_jpeg_mcu_sched.sv
// Directed bench for jpeg_mcu_sched: per-scenario tasks with hand-computed expectations.
module tb_jpeg_mcu_sched;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    jpeg_mcu_sched_if #(.MCU_W(16)) bus ();

    jpeg_mcu_sched #(.MCU_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] mode, input logic [15:0] total, input logic [15:0] rint);
        bus.cfg_mode_i      = mode;
        bus.cfg_mcu_total_i = total;
        bus.cfg_restart_i   = rint;
        bus.img_start_i     = 1'b1;
        tick();
        bus.img_start_i     = 1'b0;
    endtask

    task automatic done_pulse();
        bus.blk_done_i = 1'b1;
        tick();
        bus.blk_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.img_start_i = 1'b0; bus.cfg_mode_i = 2'd0; bus.cfg_mcu_total_i = '0;
        bus.cfg_restart_i = '0; bus.blk_done_i = 1'b0; bus.restart_ack_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (bus.active_o !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", bus.active_o); end
        checks++; if (bus.comp_id_o !== 2'd0 || bus.blk_idx_o !== 3'd0) begin failures++; $display("FAIL reset_pos got=%0d/%0d exp=0/0", bus.comp_id_o, bus.blk_idx_o); end
        checks++; if ({bus.dc_reset_o, bus.restart_req_o, bus.img_end_o, bus.err_o} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.dc_reset_o, bus.restart_req_o, bus.img_end_o, bus.err_o}); end
        checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_mode444();
        logic [1:0] exp_c [6];
        exp_c = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        start(2'd1, 16'd2, 16'd0);
        checks++; if (bus.dc_reset_o !== 1'b1 || bus.active_o !== 1'b1) begin failures++; $display("FAIL m1_start dc/act got=%b%b exp=11", bus.dc_reset_o, bus.active_o); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.comp_id_o !== exp_c[i] || bus.blk_idx_o !== 3'(i % 3)) begin failures++; $display("FAIL m1_blk%0d comp/idx got=%0d/%0d exp=%0d/%0d", i, bus.comp_id_o, bus.blk_idx_o, exp_c[i], i % 3); end
            done_pulse();
            if (i < 5) begin
                tick(); tick();
                checks++; if (bus.img_end_o !== 1'b0) begin failures++; $display("FAIL m1_early_end%0d got=%b exp=0", i, bus.img_end_o); end
            end
        end
        checks++; if (bus.img_end_o !== 1'b1 || bus.active_o !== 1'b0) begin failures++; $display("FAIL m1_end end/act got=%b%b exp=10", bus.img_end_o, bus.active_o); end
        tick();
        checks++; if (bus.img_end_o !== 1'b0) begin failures++; $display("FAIL m1_end_pulse got=%b exp=0", bus.img_end_o); end
        checks++; if (dut.state_q !== ST_DONE || bus.err_o !== 1'b0) begin failures++; $display("FAIL m1_done state/err got=%0d/%b exp=3/0", dut.state_q, bus.err_o); end
    endtask

    task automatic test_back_to_back_420();
        logic [1:0] exp_c [6];
        exp_c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        start(2'd2, 16'd1, 16'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.comp_id_o !== exp_c[i] || bus.blk_idx_o !== 3'(i)) begin failures++; $display("FAIL m2_blk%0d comp/idx got=%0d/%0d exp=%0d/%0d", i, bus.comp_id_o, bus.blk_idx_o, exp_c[i], i); end
            checks++; if (bus.img_end_o !== 1'b0) begin failures++; $display("FAIL m2_early_end%0d got=%b exp=0", i, bus.img_end_o); end
            done_pulse();
        end
        checks++; if (bus.img_end_o !== 1'b1 || bus.active_o !== 1'b0) begin failures++; $display("FAIL m2_end end/act got=%b%b exp=10", bus.img_end_o, bus.active_o); end
    endtask

    task automatic test_restart();
        start(2'd0, 16'd4, 16'd2);
        tick();
        done_pulse();
        checks++; if (bus.restart_req_o !== 1'b0 || bus.active_o !== 1'b1) begin failures++; $display("FAIL rs_first req/act got=%b%b exp=01", bus.restart_req_o, bus.active_o); end
        done_pulse();
        checks++; if (bus.restart_req_o !== 1'b1 || bus.active_o !== 1'b0) begin failures++; $display("FAIL rs_enter req/act got=%b%b exp=10", bus.restart_req_o, bus.active_o); end
        tick(); tick(); tick(); tick();
        checks++; if (bus.restart_req_o !== 1'b1) begin failures++; $display("FAIL rs_hold got=%b exp=1", bus.restart_req_o); end
        bus.restart_ack_i = 1'b1;
        tick();
        bus.restart_ack_i = 1'b0;
        checks++; if (bus.dc_reset_o !== 1'b1 || bus.active_o !== 1'b1 || bus.restart_req_o !== 1'b0) begin failures++; $display("FAIL rs_ack dc/act/req got=%b%b%b exp=110", bus.dc_reset_o, bus.active_o, bus.restart_req_o); end
        tick();
        bus.restart_ack_i = 1'b1;
        tick();
        bus.restart_ack_i = 1'b0;
        checks++; if (bus.dc_reset_o !== 1'b0 || bus.active_o !== 1'b1) begin failures++; $display("FAIL rs_stray_ack dc/act got=%b%b exp=01", bus.dc_reset_o, bus.active_o); end
        done_pulse();
        done_pulse();
        checks++; if (bus.img_end_o !== 1'b1 || bus.restart_req_o !== 1'b0) begin failures++; $display("FAIL rs_last end/req got=%b%b exp=10", bus.img_end_o, bus.restart_req_o); end
        tick();
        checks++; if (dut.state_q !== ST_DONE || bus.restart_req_o !== 1'b0) begin failures++; $display("FAIL rs_done state/req got=%0d/%b exp=3/0", dut.state_q, bus.restart_req_o); end
    endtask

    task automatic test_start_priority();
        start(2'd3, 16'd3, 16'd0);
        tick();
        done_pulse();
        checks++; if (bus.blk_idx_o !== 3'd1 || bus.comp_id_o !== 2'd0) begin failures++; $display("FAIL sp_first idx/comp got=%0d/%0d exp=1/0", bus.blk_idx_o, bus.comp_id_o); end
        bus.img_start_i = 1'b1;
        bus.blk_done_i  = 1'b1;
        tick();
        bus.img_start_i = 1'b0;
        bus.blk_done_i  = 1'b0;
        checks++; if (bus.blk_idx_o !== 3'd0 || bus.comp_id_o !== 2'd0) begin failures++; $display("FAIL sp_restart idx/comp got=%0d/%0d exp=0/0", bus.blk_idx_o, bus.comp_id_o); end
        checks++; if (bus.dc_reset_o !== 1'b1 || bus.err_o !== 1'b0 || bus.active_o !== 1'b1) begin failures++; $display("FAIL sp_flags dc/err/act got=%b%b%b exp=101", bus.dc_reset_o, bus.err_o, bus.active_o); end
        done_pulse();
        done_pulse();
        checks++; if (bus.blk_idx_o !== 3'd2 || bus.comp_id_o !== 2'd1) begin failures++; $display("FAIL sp_cb idx/comp got=%0d/%0d exp=2/1", bus.blk_idx_o, bus.comp_id_o); end
        done_pulse();
        checks++; if (bus.blk_idx_o !== 3'd3 || bus.comp_id_o !== 2'd2) begin failures++; $display("FAIL sp_cr idx/comp got=%0d/%0d exp=3/2", bus.blk_idx_o, bus.comp_id_o); end
    endtask

    task automatic test_total_zero();
        int ends;
        ends = 0;
        start(2'd1, 16'd0, 16'd0);
        checks++; if (bus.dc_reset_o !== 1'b1) begin failures++; $display("FAIL z_dc got=%b exp=1", bus.dc_reset_o); end
        for (int i = 0; i < 4; i++) begin
            if (bus.img_end_o === 1'b1) ends++;
            if (i < 3) tick();
        end
        checks++; if (ends !== 1) begin failures++; $display("FAIL z_end_count got=%0d exp=1", ends); end
        checks++; if (bus.err_o !== 1'b0 || bus.active_o !== 1'b0) begin failures++; $display("FAIL z_pre err/act got=%b%b exp=00", bus.err_o, bus.active_o); end
        done_pulse();
        tick(); tick();
        checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL z_err_sticky got=%b exp=1", bus.err_o); end
        start(2'd0, 16'd1, 16'd0);
        checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL z_err_clear got=%b exp=0", bus.err_o); end
    endtask

    task automatic test_reset_in_restart();
        start(2'd0, 16'd5, 16'd1);
        tick();
        done_pulse();
        checks++; if (bus.restart_req_o !== 1'b1) begin failures++; $display("FAIL rr_req got=%b exp=1", bus.restart_req_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus.active_o, bus.dc_reset_o, bus.restart_req_o, bus.img_end_o, bus.err_o, bus.comp_id_o, bus.blk_idx_o} !== 10'b0) begin failures++; $display("FAIL rr_outs got=%b exp=0", {bus.active_o, bus.dc_reset_o, bus.restart_req_o, bus.img_end_o, bus.err_o, bus.comp_id_o, bus.blk_idx_o}); end
        checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL rr_state got=%0d exp=0", dut.state_q); end
        bus.restart_ack_i = 1'b1;
        tick();
        bus.restart_ack_i = 1'b0;
        checks++; if (bus.active_o !== 1'b0 || bus.dc_reset_o !== 1'b0 || dut.state_q !== ST_IDLE) begin failures++; $display("FAIL rr_ack act/dc/state got=%b%b%0d exp=000", bus.active_o, bus.dc_reset_o, dut.state_q); end
        done_pulse();
        checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL rr_idle_err got=%b exp=1", bus.err_o); end
    endtask

    initial begin
        test_reset();
        test_mode444();
        test_back_to_back_420();
        test_restart();
        test_start_priority();
        test_total_zero();
        test_reset_in_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
